mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified instruction/data memory port of the multicycle core between the core itself and a program loader/debug requester. It sits between the memory-address mux/write path and the MEMORY instance. It grants the port one requester at a time using registered round-robin grants with a bounded burst length. It also exports a saturating count of cycles the core spent waiting.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_burst_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCore = 2'b01,
        StLdr  = 2'b10
    } arb_state_e;

    localparam logic ReqCore = 1'b0;
    localparam logic ReqLdr  = 1'b1;

    // One spare bit so the counter can always hold Max_Burst-1, including Max_Burst=1.
    function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/arb_burst_counter.sv
// Burst-length counter for the port arbiter: clear has priority, increment saturates.
module arb_burst_counter #(
    parameter int unsigned Width  = 3,
    parameter int unsigned SatVal = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    localparam logic [Width-1:0] Sat = Width'(SatVal);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != Sat)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and a loader/debug requester,
// with a bounded burst length and a saturating core stall counter.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned Data_Size = 32,
    parameter int unsigned Addr_Size = 32,
    parameter int unsigned Max_Burst = 4,
    parameter int unsigned Cnt_Width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [Addr_Size-1:0] core_addr,
    input  logic [Data_Size-1:0] core_wdata,
    output logic                 core_gnt,
    output logic [Data_Size-1:0] core_rdata,
    input  logic                 ldr_req,
    input  logic                 ldr_we,
    input  logic [Addr_Size-1:0] ldr_addr,
    input  logic [Data_Size-1:0] ldr_wdata,
    output logic                 ldr_gnt,
    output logic [Data_Size-1:0] ldr_rdata,
    output logic [Addr_Size-1:0] mem_addr,
    output logic [Data_Size-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [Data_Size-1:0] mem_rdata,
    output logic [Cnt_Width-1:0] stall_cnt
);

    localparam int unsigned         BurstW    = burst_cnt_width(Max_Burst);
    localparam logic [BurstW-1:0]   BurstLast = BurstW'(Max_Burst - 1);

    arb_state_e           state_q, state_d;
    logic                 last_srv_q, last_srv_d;
    logic                 core_gnt_q, ldr_gnt_q;
    logic                 burst_clr, burst_inc;
    logic [BurstW-1:0]    burst_cnt;
    logic                 own_req, oth_req, own_id;
    arb_state_e           oth_state;
    logic [Cnt_Width-1:0] stall_q, stall_d;

    arb_burst_counter #(
        .Width  (BurstW),
        .SatVal (Max_Burst - 1)
    ) u_burst_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (burst_clr),
        .inc_i   (burst_inc),
        .count_o (burst_cnt)
    );

    always_comb begin
        own_req    = (state_q == StLdr) ? ldr_req : core_req;
        oth_req    = (state_q == StLdr) ? core_req : ldr_req;
        own_id     = (state_q == StLdr) ? ReqLdr : ReqCore;
        oth_state  = (state_q == StLdr) ? StCore : StLdr;
        state_d    = state_q;
        last_srv_d = last_srv_q;
        burst_clr  = 1'b0;
        burst_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                burst_clr = 1'b1;
                if (core_req && ldr_req) begin
                    state_d = (last_srv_q == ReqLdr) ? StCore : StLdr;
                end else if (core_req) begin
                    state_d = StCore;
                end else if (ldr_req) begin
                    state_d = StLdr;
                end
            end
            StCore, StLdr: begin
                if (own_req) begin
                    if (oth_req && (burst_cnt == BurstLast)) begin
                        state_d    = oth_state;
                        burst_clr  = 1'b1;
                        last_srv_d = own_id;
                    end else begin
                        burst_inc = 1'b1;
                    end
                end else begin
                    state_d    = oth_req ? oth_state : StIdle;
                    burst_clr  = 1'b1;
                    last_srv_d = own_id;
                end
            end
            default: begin
                state_d   = StIdle;
                burst_clr = 1'b1;
            end
        endcase
    end

    // Grants are registered copies of the next state so they always match state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            last_srv_q <= ReqLdr;
            core_gnt_q <= 1'b0;
            ldr_gnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_srv_q <= last_srv_d;
            core_gnt_q <= (state_d == StCore);
            ldr_gnt_q  <= (state_d == StLdr);
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (core_req && !core_gnt_q && (stall_q != '1)) begin
            stall_d = stall_q + Cnt_Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // A holder that has dropped its request never issues a write.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        unique case (state_q)
            StCore: begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_we    = core_we & core_req;
            end
            StLdr: begin
                mem_addr  = ldr_addr;
                mem_wdata = ldr_wdata;
                mem_we    = ldr_we & ldr_req;
            end
            default: begin
            end
        endcase
    end

    assign core_gnt   = core_gnt_q;
    assign ldr_gnt    = ldr_gnt_q;
    assign core_rdata = mem_rdata;
    assign ldr_rdata  = mem_rdata;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (Max_Burst 4/1/64) on shared stimulus, checked
// against a run-length model of the arbitration rules, plus directed literal expectations.
module tb_mem_port_arbiter;

    localparam int NI = 3;
    localparam int MB   [NI] = '{4, 1, 64};
    localparam int CMAX [NI] = '{65535, 15, 31};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [31:0] ldr_addr = '0, ldr_wdata = '0;

    logic        c_gnt [NI];
    logic        l_gnt [NI];
    logic        m_we  [NI];
    logic [31:0] c_rd  [NI];
    logic [31:0] l_rd  [NI];
    logic [31:0] m_addr[NI];
    logic [31:0] m_wd  [NI];
    logic [31:0] m_rd  [NI];
    logic [15:0] st0;
    logic [3:0]  st1;
    logic [4:0]  st2;
    logic [15:0] st    [NI];
    logic [31:0] mem   [NI][256];

    int checks = 0;
    int errors = 0;

    // Model state: owner 0=none 1=core 2=loader; run = granted cycles in current tenure.
    int owner [NI];
    int run   [NI];
    int last  [NI];
    int stl   [NI];

    always #5 clk = ~clk;

    assign st[0] = st0;
    assign st[1] = {12'b0, st1};
    assign st[2] = {11'b0, st2};
    assign m_rd[0] = mem[0][m_addr[0][9:2]];
    assign m_rd[1] = mem[1][m_addr[1][9:2]];
    assign m_rd[2] = mem[2][m_addr[2][9:2]];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (m_we[k]) mem[k][m_addr[k][9:2]] <= m_wd[k];
        end
    end

    mem_port_arbiter #(.Data_Size(32), .Addr_Size(32), .Max_Burst(4), .Cnt_Width(16)) u0 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(c_gnt[0]), .core_rdata(c_rd[0]),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(l_gnt[0]), .ldr_rdata(l_rd[0]),
        .mem_addr(m_addr[0]), .mem_wdata(m_wd[0]), .mem_we(m_we[0]), .mem_rdata(m_rd[0]),
        .stall_cnt(st0)
    );

    mem_port_arbiter #(.Data_Size(32), .Addr_Size(32), .Max_Burst(1), .Cnt_Width(4)) u1 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(c_gnt[1]), .core_rdata(c_rd[1]),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(l_gnt[1]), .ldr_rdata(l_rd[1]),
        .mem_addr(m_addr[1]), .mem_wdata(m_wd[1]), .mem_we(m_we[1]), .mem_rdata(m_rd[1]),
        .stall_cnt(st1)
    );

    mem_port_arbiter #(.Data_Size(32), .Addr_Size(32), .Max_Burst(64), .Cnt_Width(5)) u2 (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(c_gnt[2]), .core_rdata(c_rd[2]),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(l_gnt[2]), .ldr_rdata(l_rd[2]),
        .mem_addr(m_addr[2]), .mem_wdata(m_wd[2]), .mem_we(m_we[2]), .mem_rdata(m_rd[2]),
        .stall_cnt(st2)
    );

    function automatic void model_step(input int k, output int o, output int r, output int l,
                                       output int s);
        logic own, oth;
        o = owner[k];
        r = run[k];
        l = last[k];
        s = stl[k];
        if (core_req && (owner[k] != 1) && (s < CMAX[k])) s = s + 1;
        if (o == 0) begin
            if (core_req && ldr_req) o = (l == 1) ? 2 : 1;
            else if (core_req)       o = 1;
            else if (ldr_req)        o = 2;
            r = (o != 0) ? 1 : 0;
        end else begin
            own = (o == 1) ? core_req : ldr_req;
            oth = (o == 1) ? ldr_req : core_req;
            if (own && !(oth && (r >= MB[k]))) begin
                if (r < MB[k]) r = r + 1;
            end else begin
                l = o;
                o = oth ? (3 - o) : 0;
                r = oth ? 1 : 0;
            end
        end
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int o, r, l, s;
        if (!rst) begin
            for (int k = 0; k < NI; k++) begin
                owner[k] <= 0;
                run[k]   <= 0;
                last[k]  <= 2;
                stl[k]   <= 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                model_step(k, o, r, l, s);
                owner[k] <= o;
                run[k]   <= r;
                last[k]  <= l;
                stl[k]   <= s;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        int          o;
        logic [31:0] ea, ew;
        logic        ewe;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                o   = owner[k];
                ea  = (o == 1) ? core_addr  : (o == 2) ? ldr_addr  : 32'h0;
                ew  = (o == 1) ? core_wdata : (o == 2) ? ldr_wdata : 32'h0;
                ewe = (o == 1) ? (core_we & core_req) : (o == 2) ? (ldr_we & ldr_req) : 1'b0;
                chk($sformatf("u%0d.gnt", k), {62'b0, c_gnt[k], l_gnt[k]},
                    {62'b0, (o == 1), (o == 2)});
                chk($sformatf("u%0d.mem_addr", k), {32'b0, m_addr[k]}, {32'b0, ea});
                chk($sformatf("u%0d.mem_wdata", k), {32'b0, m_wd[k]}, {32'b0, ew});
                chk($sformatf("u%0d.mem_we", k), {63'b0, m_we[k]}, {63'b0, ewe});
                chk($sformatf("u%0d.stall", k), {48'b0, st[k]}, 64'(stl[k]));
                chk($sformatf("u%0d.rdata", k), {c_rd[k], l_rd[k]},
                    {mem[k][ea[9:2]], mem[k][ea[9:2]]});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        ldr_req  = 1'b0; ldr_we  = 1'b0; ldr_addr  = '0; ldr_wdata  = '0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] old;
        fork
            compare_loop();
        join_none

        // Reset values, then first grant latency.
        @(negedge clk);
        chk("reset.gnt", {62'b0, c_gnt[0], l_gnt[0]}, 64'd0);
        chk("reset.mem_we", {63'b0, m_we[0]}, 64'd0);
        chk("reset.mem_addr", {32'b0, m_addr[0]}, 64'd0);
        chk("reset.mem_wdata", {32'b0, m_wd[0]}, 64'd0);
        chk("reset.stall", {48'b0, st0}, 64'd0);
        step();
        rst = 1'b1;
        core_req = 1'b1;
        core_addr = 32'h10;
        @(negedge clk);
        chk("lat.idle_gnt", {63'b0, c_gnt[0]}, 64'd0);
        step();
        @(negedge clk);
        chk("lat.core_gnt", {63'b0, c_gnt[0]}, 64'd1);
        chk("lat.mem_addr", {32'b0, m_addr[0]}, 64'h10);
        chk("lat.stall", {48'b0, st0}, 64'd1);

        // Contention from idle: bursts of 4 / 1 / 64.
        do_reset();
        core_req = 1'b1; core_addr = 32'h100;
        ldr_req  = 1'b1; ldr_addr  = 32'h200;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("cont4.core c%0d", c), {63'b0, c_gnt[0]},
                64'(((c >= 1) && (c <= 4)) || (c == 9)));
            chk($sformatf("cont4.ldr c%0d", c), {63'b0, l_gnt[0]}, 64'((c >= 5) && (c <= 8)));
            chk($sformatf("cont1.core c%0d", c), {63'b0, c_gnt[1]}, 64'(c % 2));
            chk($sformatf("cont64.core c%0d", c), {63'b0, c_gnt[2]}, 64'(c >= 1));
            if (c == 8) chk("cont4.stall_end_ldr", {48'b0, st0}, 64'd4);
            if (c == 9) chk("cont4.stall_regrant", {48'b0, st0}, 64'd5);
            step();
        end

        // Loader drops its request for one cycle while holding the grant with we=1.
        do_reset();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h80; ldr_wdata = 32'h55;
        @(negedge clk);
        chk("drop.idle", {63'b0, l_gnt[0]}, 64'd0);
        step();
        core_req = 1'b1; core_addr = 32'h84;
        @(negedge clk);
        chk("drop.ldr_write", {62'b0, l_gnt[0], m_we[0]}, 64'd3);
        step();
        ldr_req = 1'b0;
        @(negedge clk);
        chk("drop.no_write", {62'b0, l_gnt[0], m_we[0]}, 64'd2);
        step();
        @(negedge clk);
        chk("drop.handover", {62'b0, c_gnt[0], l_gnt[0]}, 64'd2);

        // Loader writes, core reads it back.
        do_reset();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h40; ldr_wdata = 32'hDEADBEEF;
        step();
        @(negedge clk);
        chk("wr.mem_addr", {32'b0, m_addr[0]}, 64'h40);
        chk("wr.mem_wdata_we", {31'b0, m_wd[0], m_we[0]}, {31'b0, 32'hDEADBEEF, 1'b1});
        step();
        ldr_req = 1'b0; ldr_we = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
        step();
        @(negedge clk);
        chk("rd.core_gnt", {63'b0, c_gnt[0]}, 64'd1);
        chk("rd.core_rdata", {32'b0, c_rd[0]}, 64'hDEADBEEF);

        // Reset asserted mid-write.
        do_reset();
        old = mem[0][17];
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h44; core_wdata = old ^ 32'hA5A5A5A5;
        step();
        chk("rstmid.before", {62'b0, c_gnt[0], m_we[0]}, 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid.after", {62'b0, c_gnt[0], m_we[0]}, 64'd0);
        step();
        chk("rstmid.mem_kept", {32'b0, mem[0][17]}, {32'b0, old});

        // Stall counter saturation on the 5-bit instance.
        do_reset();
        ldr_req = 1'b1;
        step();
        core_req = 1'b1;
        repeat (37) step();
        @(negedge clk);
        chk("sat.stall", {48'b0, st[2]}, 64'd31);
        chk("sat.ldr_gnt", {63'b0, l_gnt[2]}, 64'd1);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!rst)                            rst = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst = 1'b0;
            if (!(core_req && (owner[0] != 1))) begin
                core_req   = ($urandom_range(0, 9) < 6);
                core_we    = 1'($urandom_range(0, 1));
                core_addr  = 32'($urandom_range(0, 255)) << 2;
                core_wdata = $urandom;
            end
            if (!(ldr_req && (owner[0] != 2))) begin
                ldr_req   = ($urandom_range(0, 9) < 5);
                ldr_we    = 1'($urandom_range(0, 1));
                ldr_addr  = 32'($urandom_range(0, 255)) << 2;
                ldr_wdata = $urandom;
            end
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
